dmem_sram_bridge: RTL

//  Data-side bus stage directly downstream of the M-stage load/store formatter. Converts its
//  per-cycle SRAM strobes (wen/addr/wdata) into an SRAM-like req/addr_ok/data_ok transaction.

---
 rtl/dmem_sram_bridge_pkg.sv | 16 +
 rtl/dmem_wen_decode.sv | 33 +++
 rtl/dmem_sram_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types for the data-side SRAM bridge:
// FSM state codes and bus size encodings.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_ADDR = 2'd1,
    BR_DATA = 2'd2,
    BR_HOLD = 2'd3
  } br_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/dmem_wen_decode.sv
// Byte-strobe decoder: maps formatter strobes to
// bus size and lane offset (big-endian lanes).
module dmem_wen_decode
  import dmem_sram_bridge_pkg::*;
(
  input  logic [3:0] m_wen,
  input  logic       m_ren,
  output logic [1:0] size,
  output logic [1:0] off,
  output logic       legal
);

  always_comb begin
    size  = SIZE_W;
    off   = 2'b00;
    legal = 1'b0;
    if (m_ren) begin
      legal = 1'b1;
    end else begin
      unique case (m_wen)
        4'b1111: begin size = SIZE_W; off = 2'b00; legal = 1'b1; end
        4'b1100: begin size = SIZE_H; off = 2'b00; legal = 1'b1; end
        4'b0011: begin size = SIZE_H; off = 2'b10; legal = 1'b1; end
        4'b1000: begin size = SIZE_B; off = 2'b00; legal = 1'b1; end
        4'b0100: begin size = SIZE_B; off = 2'b01; legal = 1'b1; end
        4'b0010: begin size = SIZE_B; off = 2'b10; legal = 1'b1; end
        4'b0001: begin size = SIZE_B; off = 2'b11; legal = 1'b1; end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage data bridge: SRAM strobes to req/addr_ok/data_ok,
// with pipeline stall and raw read-word return.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_ren,
  input  logic [3:0]        m_wen,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_flush,
  input  logic              stall_other,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  if (DATA_W != 32) begin : g_bad_width
    $error("dmem_sram_bridge: DATA_W must be 32");
  end

  br_state_e         state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]        dec_size;
  logic [1:0]        dec_off;
  logic              dec_legal;
  logic              start;
  logic [ADDR_W-1:0] cur_addr;
  logic              unused_addr;

  dmem_wen_decode u_dec (
    .m_wen (m_wen),
    .m_ren (m_ren),
    .size  (dec_size),
    .off   (dec_off),
    .legal (dec_legal)
  );

  assign unused_addr = ^m_addr[1:0];
  assign cur_addr    = {m_addr[ADDR_W-1:2], dec_off};
  assign start = m_valid & ~m_flush & dec_legal
               & (state_q == BR_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BR_IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= SIZE_W;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      BR_IDLE: begin
        cancel_d = 1'b0;
        if (start) begin
          rd_d    = m_ren;
          wr_d    = ~m_ren;
          size_d  = dec_size;
          addr_d  = cur_addr;
          wdata_d = m_wdata;
          state_d = data_addr_ok ? BR_DATA : BR_ADDR;
        end
      end
      BR_ADDR: begin
        if (m_flush) cancel_d = 1'b1;
        if (data_addr_ok) state_d = BR_DATA;
      end
      BR_DATA: begin
        if (m_flush) cancel_d = 1'b1;
        if (data_data_ok) begin
          if (rd_q && !cancel_q) rdata_d = data_rdata;
          if (stall_other && !cancel_q && !m_flush) begin
            state_d = BR_HOLD;
          end else begin
            state_d  = BR_IDLE;
            cancel_d = 1'b0;
          end
        end
      end
      BR_HOLD: begin
        if (!stall_other || m_flush) state_d = BR_IDLE;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  // Fields follow m_* only in the issue cycle; afterwards the latch holds them.
  always_comb begin
    data_req   = 1'b0;
    data_wr    = wr_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wdata = wdata_q;
    if (state_q == BR_IDLE) begin
      data_req   = start;
      data_wr    = ~m_ren;
      data_size  = dec_size;
      data_addr  = cur_addr;
      data_wdata = m_wdata;
    end else if (state_q == BR_ADDR) begin
      data_req = 1'b1;
    end
  end

  assign stall_o = start
                 | (state_q == BR_ADDR)
                 | ((state_q == BR_DATA) & ~data_data_ok)
                 | ((state_q == BR_DATA) & cancel_q);

  assign rdata_o = ((state_q == BR_DATA) && data_data_ok)
                 ? data_rdata : rdata_q;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(state_q == BR_ADDR && data_data_ok));
    end
  end

endmodule
